// File: rtl/rom_pkg.sv
// Shared constants and types for the ROM read sequencer, the ROM and its bench.
package rom_pkg;

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned DATA_W   = 4;
  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam int unsigned ROM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One captured ROM word together with the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Address increment; wraps naturally from ROM_DEPTH-1 back to 0.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/rom_out_stage.sv
// Valid/ready output register for captured ROM words.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   i_load          - capture i_beat this cycle (caller guarantees o_can_load_c)
//   i_beat          - word + address to capture
//   i_ready         - downstream ready
//   o_valid         - registered word available
//   o_beat          - registered word + address, held while stalled
//   o_can_load_c    - register is empty or being emptied this cycle
//   o_accept_c      - handshake happening this cycle
module rom_out_stage
  import rom_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  beat_t i_beat,
  input  logic  i_ready,
  output logic  o_valid,
  output beat_t o_beat,
  output logic  o_can_load_c,
  output logic  o_accept_c
);

  logic  r_valid;
  beat_t r_beat;

  assign o_can_load_c = ~r_valid | i_ready;
  assign o_accept_c   = r_valid & i_ready;

  // Load wins over drain so back-to-back beats flow at one per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_beat  <= i_beat;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_beat  = r_beat;

endmodule

// File: rtl/rom_read_seq.sv
// Burst address sequencer in front of the asynchronous 64x4 ROM. Accepts a
// (start_addr, count) command, walks the ROM address, captures rom_dout each
// cycle the output register can take it, and streams word+address downstream.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start/start_addr/count   - burst command, sampled only in IDLE
//   busy                     - burst in progress (READ or DRAIN)
//   done                     - one-cycle completion pulse
//   rom_en/rom_addr          - ROM control, rom_dout returns combinationally
//   out_valid/out_data/out_addr/out_ready - output stream
module rom_read_seq
  import rom_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              out_ready
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_busy;
  logic              r_done;
  logic              r_rom_en;

  logic [ADDR_W-1:0] w_cur_addr_nxt;
  logic [CNT_W-1:0]  w_remaining_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_rom_en_nxt;

  logic              w_can_load;
  logic              w_accept;
  logic              w_cap;
  beat_t             w_cap_beat;
  beat_t             w_out_beat;

  // A capture happens in READ whenever the output register can accept a word.
  assign w_cap            = (r_state == READ) && w_can_load;
  assign w_cap_beat.addr  = r_cur_addr;
  assign w_cap_beat.data  = rom_dout;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = (count == '0) ? DONE : READ;
      end
      READ: begin
        if (w_cap && (r_remaining == CNT_W'(1))) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_accept) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values; status flags are decoded from the next
  // state so the registered outputs line up with the state they describe.
  always_comb begin
    w_cur_addr_nxt  = r_cur_addr;
    w_remaining_nxt = r_remaining;
    w_busy_nxt      = (w_state_nxt == READ) || (w_state_nxt == DRAIN);
    w_done_nxt      = (w_state_nxt == DONE);
    w_rom_en_nxt    = (w_state_nxt == READ);
    if ((r_state == IDLE) && start && (count != '0)) begin
      w_cur_addr_nxt  = start_addr;
      w_remaining_nxt = count;
    end else if (w_cap) begin
      w_cur_addr_nxt  = addr_inc(r_cur_addr);
      w_remaining_nxt = r_remaining - CNT_W'(1);
    end
  end

  // Registered outputs and burst counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rom_en    <= 1'b0;
    end else begin
      r_cur_addr  <= w_cur_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_rom_en    <= w_rom_en_nxt;
    end
  end

  rom_out_stage u_out_stage (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_cap),
    .i_beat       (w_cap_beat),
    .i_ready      (out_ready),
    .o_valid      (out_valid),
    .o_beat       (w_out_beat),
    .o_can_load_c (w_can_load),
    .o_accept_c   (w_accept)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign rom_en   = r_rom_en;
  assign rom_addr = r_cur_addr;
  assign out_data = w_out_beat.data;
  assign out_addr = w_out_beat.addr;

endmodule

// File: tb/tb_rom_read_seq.sv
// Scoreboard bench for rom_read_seq with a behavioural asynchronous ROM.
module tb_rom_read_seq;
  import rom_pkg::*;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_ready;

  int n_chk;
  int n_pass;
  int beats;
  int done_cnt;
  bit mon_en;
  beat_t sb[$];

  bit                prev_stall;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;

  rom_read_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(32'(a) * 32'd5 + 32'(a >> 3) + 32'd7);
  endfunction

  always_comb rom_dout = rom_word(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Monitor: pops the scoreboard on each handshake, checks stall stability.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_addr", 32'(out_addr), 32'(prev_addr));
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_addr", 32'(out_addr), 32'(e.addr));
          chk("beat_data", 32'(out_data), 32'(e.data));
        end
        beats++;
      end
      if (done) begin
        done_cnt++;
        chk("done_not_busy", 32'(busy), 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_addr  = out_addr;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_burst(input int a, input int c, input bit push);
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = ADDR_W'(a);
    count      = CNT_W'(c);
    if (push) begin
      for (int i = 0; i < c; i++) begin
        beat_t b;
        b.addr = ADDR_W'(a + i);
        b.data = rom_word(b.addr);
        sb.push_back(b);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done; exp_k is the expected number of negedges until it shows.
  task automatic wait_done(input string tag, input int exp_k, input int budget);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    if (seen) chk({tag, "_done_latency"}, 32'(k), 32'(exp_k));
  endtask

  task automatic post_burst(input string tag, input int b0, input int d0, input int nbeats);
    @(negedge clk);
    chk({tag, "_done_pulse_len"}, 32'(done), 0);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_beats"}, 32'(beats - b0), 32'(nbeats));
    chk({tag, "_done_count"}, 32'(done_cnt - d0), 1);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
  endtask

  initial begin
    int b0;
    int d0;
    int guard;
    n_chk = 0; n_pass = 0; beats = 0; done_cnt = 0; mon_en = 1'b0;
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    rst = 1'b1; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rom_en", 32'(rom_en), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic burst 1..4
    b0 = beats; d0 = done_cnt;
    start_burst(1, 4, 1'b1);
    @(negedge clk);
    chk("basic_busy", 32'(busy), 1);
    chk("basic_rom_en", 32'(rom_en), 1);
    chk("basic_rom_addr", 32'(rom_addr), 1);
    chk("basic_first_valid", 32'(out_valid), 0);
    wait_done("basic", 5, 40);
    post_burst("basic", b0, d0, 4);

    // Wrap-around 62,63,0,1
    b0 = beats; d0 = done_cnt;
    start_burst(62, 4, 1'b1);
    @(negedge clk); chk("wrap_rom_addr0", 32'(rom_addr), 62);
    @(negedge clk); chk("wrap_rom_addr1", 32'(rom_addr), 63);
    @(negedge clk); chk("wrap_rom_addr2", 32'(rom_addr), 0);
    wait_done("wrap", 3, 40);
    post_burst("wrap", b0, d0, 4);

    // Back-pressure from the first beat
    b0 = beats; d0 = done_cnt;
    out_ready = 1'b0;
    start_burst(20, 3, 1'b1);
    @(negedge clk); chk("bp_rom_addr0", 32'(rom_addr), 20);
    @(negedge clk);
    chk("bp_first_valid", 32'(out_valid), 1);
    chk("bp_first_addr", 32'(out_addr), 20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(out_data), 32'(rom_word(ADDR_W'(20))));
      chk("bp_hold_addr", 32'(out_addr), 20);
      chk("bp_rom_addr_hold", 32'(rom_addr), 21);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("bp", 4, 40);
    post_burst("bp", b0, d0, 3);

    // Zero count
    b0 = beats; d0 = done_cnt;
    start_burst(5, 0, 1'b1);
    wait_done("zero", 1, 20);
    post_burst("zero", b0, d0, 0);

    // Full sweep
    b0 = beats; d0 = done_cnt;
    start_burst(0, 64, 1'b1);
    wait_done("sweep", 66, 200);
    post_burst("sweep", b0, d0, 64);

    // Start while busy is ignored
    b0 = beats; d0 = done_cnt;
    start_burst(44, 5, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; start_addr = ADDR_W'(33); count = CNT_W'(2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", 4, 40);
    post_burst("busy_start", b0, d0, 5);
    repeat (5) @(negedge clk);
    chk("busy_start_quiet_beats", 32'(beats - b0), 5);
    chk("busy_start_quiet_done", 32'(done_cnt - d0), 1);

    // Reset mid-burst
    b0 = beats; d0 = done_cnt;
    start_burst(10, 8, 1'b1);
    guard = 0;
    while ((beats - b0) < 3 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    chk("midrst_beats_reached", 32'(beats - b0 >= 3), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rom_en", 32'(rom_en), 0);
    chk("midrst_rom_addr", 32'(rom_addr), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_out_addr", 32'(out_addr), 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - d0), 0);
    chk("midrst_idle", 32'(busy), 0);

    // Recovery after reset
    b0 = beats; d0 = done_cnt;
    start_burst(3, 2, 1'b1);
    wait_done("recover", 4, 40);
    post_burst("recover", b0, d0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_read_seq.md
Name: rom_read_seq

Overview:
Address sequencer and data capture stage placed directly upstream of the asynchronous 64x4 ROM (rom_asyn). It accepts a burst command (start address, word count), drives the ROM's en/addr inputs, and captures the combinational ROM output on the clock edge. Each captured word is presented with its address on a valid/ready stream to downstream logic. It replaces hand-driven address stimulus with a reusable, back-pressure-aware fetch engine.

Parameters:
ADDR_W, 6, ROM address width; ROM depth = 2**ADDR_W = 64
DATA_W, 4, ROM word width
CNT_W, ADDR_W+1 (7), burst count width; allows counts 0..64

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  burst request; sampled only in IDLE
start_addr  input  ADDR_W  first ROM address of burst
count  input  CNT_W  number of words to read (0..64)
busy  output  1  high from the cycle after accepted start until done pulse
done  output  1  one-cycle pulse: burst complete
rom_en  output  1  to ROM en
rom_addr  output  ADDR_W  to ROM addr
rom_dout  input  DATA_W  from ROM dout, combinational on rom_addr
out_valid  output  1  captured word available
out_data  output  DATA_W  captured ROM word
out_addr  output  ADDR_W  address the word was read from
out_ready  input  1  downstream accepts word when out_valid & out_ready

Behaviour:
- Reset (rst=1 at edge): state=IDLE; busy=0, done=0, rom_en=0, rom_addr=0, out_valid=0, out_data=0, out_addr=0. Reset mid-burst aborts immediately; no done pulse; pending word discarded.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: rom_en=0. start=1 with count!=0 -> READ; cur_addr<=start_addr, remaining<=count. start=1 with count=0 -> DONE (no beats). start=0 -> stay.
- READ: rom_en=1, rom_addr=cur_addr (registered). Capture permitted when out_valid=0 or out_ready=1. On capture: out_data<=rom_dout, out_addr<=cur_addr, out_valid<=1, cur_addr<=cur_addr+1 (mod 64, 63 wraps to 0), remaining<=remaining-1. Capture with remaining=1 -> DRAIN. No capture (stall) -> rom_addr and remaining hold.
- DRAIN: rom_en=0; wait for out_valid & out_ready -> out_valid<=0, state DONE.
- DONE: done=1 for exactly one cycle; busy=0; -> IDLE.
- out_valid & !out_ready: out_data/out_addr/out_valid held stable (no change until accepted).
- Handshake without new capture: out_valid<=0.
- Latency: start accepted at edge E0; first rom_addr valid after E0; first out_valid after E1. Throughput 1 word/cycle when out_ready held high; burst of N words with no stall: done high in cycle after edge E0+N+1.
- start while busy ignored; start_addr/count sampled only on acceptance.
- busy = (state==READ or DRAIN).

Decomposition:
- Package rom_pkg: ADDR_W, DATA_W, CNT_W constants; state enum type (IDLE, READ, DRAIN, DONE); shared with ROM and its bench.
- One natural sub-module: rom_out_stage (valid/ready output register holding out_data/out_addr, load-enable and drain logic); FSM and address counter stay in top.

Test Plan:
- Reset mid-burst: start_addr=10, count=8, assert rst after 3 beats -> all outputs 0 next cycle, no done, state IDLE.
- Basic burst: start_addr=1, count=4, out_ready=1 -> out_addr 1,2,3,4 on consecutive cycles, out_data = ROM[1..4], done pulse once, busy low after.
- Wrap-around: start_addr=62, count=4 -> out_addr 62,63,0,1; rom_addr wraps 63->0.
- Back-pressure: start_addr=20, count=3, out_ready low 3 cycles after first beat -> out_data/out_addr held at ROM[20]/20, rom_addr held at 21; resumes 21,22 when out_ready=1; exactly 3 beats.
- Zero count and full sweep: count=0 -> done next cycle after DONE entry, no out_valid; start_addr=0, count=64 -> 64 beats addr 0..63, each data matches ROM image.
- Start while busy: second start (addr=33, count=2) during burst from 44 -> ignored; only original burst beats observed.
